// File: rtl/periph_irq_arbiter_pkg.sv
// Shared definitions for the peripheral interrupt arbiter: register map,
// default sizing and the per-source gateway state encoding.
package periph_irq_arbiter_pkg;

  localparam int NUM_SRC_DEF = 16;
  localparam int PRIO_W_DEF  = 3;
  localparam int ID_W        = 5;

  localparam logic [7:0] ADDR_PENDING   = 8'h00;
  localparam logic [7:0] ADDR_ENABLE    = 8'h04;
  localparam logic [7:0] ADDR_EDGE_SEL  = 8'h08;
  localparam logic [7:0] ADDR_THRESHOLD = 8'h0C;
  localparam logic [7:0] ADDR_CLAIM     = 8'h10;
  localparam logic [7:0] ADDR_PRIO_BASE = 8'h40;

  typedef enum logic [1:0] {
    GW_IDLE       = 2'd0,
    GW_PENDING    = 2'd1,
    GW_IN_SERVICE = 2'd2
  } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: turns a raw line into a single pending
// request and holds it off until the handler signals completion.
module irq_gateway
  import periph_irq_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_sel,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  gw_state_e state, state_nxt;
  logic      src_q;
  logic      trig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GW_IDLE;
      src_q <= 1'b0;
    end else begin
      state <= state_nxt;
      src_q <= src;
    end
  end

  assign trig = edge_sel ? (src & ~src_q) : src;

  // Triggers outside IDLE fall through unused, so a claim in the same
  // cycle as a fresh trigger simply wins.
  always_comb begin
    state_nxt = state;
    case (state)
      GW_IDLE:       if (trig)     state_nxt = GW_PENDING;
      GW_PENDING:    if (claim)    state_nxt = GW_IN_SERVICE;
      GW_IN_SERVICE: if (complete) state_nxt = GW_IDLE;
      default:                     state_nxt = GW_IDLE;
    endcase
  end

  assign pending = (state == GW_PENDING);

endmodule

// File: rtl/periph_irq_arbiter.sv
// Peripheral interrupt arbiter: register file, NUM_SRC gateways and a
// registered highest-priority selector driving the core's external interrupt.
module periph_irq_arbiter
  import periph_irq_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int PRIO_W  = PRIO_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [7:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  input  logic               bus_we,
  input  logic               bus_re,
  output logic [31:0]        bus_rdata,
  output logic               bus_ready,
  output logic               ext_irq,
  output logic [ID_W-1:0]    claim_id
);

  logic [NUM_SRC-1:0]             enable;
  logic [NUM_SRC-1:0]             edge_sel;
  logic [PRIO_W-1:0]              threshold;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio;
  logic [NUM_SRC-1:0]             pending_vec;

  logic [PRIO_W-1:0] win_prio;
  logic [PRIO_W-1:0] best_prio;
  logic [ID_W-1:0]   best_id;

  logic       rd_en;
  logic       claim_fire;
  logic       cmpl_hit;
  logic [7:0] prio_off;
  logic       prio_hit;
  logic [31:0] rdata_d;

  // A simultaneous write and read is handled as a write only.
  assign rd_en      = bus_re && !bus_we;
  assign claim_fire = rd_en && (bus_addr == ADDR_CLAIM);
  assign cmpl_hit   = bus_we && (bus_addr == ADDR_CLAIM);

  assign prio_off = bus_addr - ADDR_PRIO_BASE;
  assign prio_hit = (bus_addr >= ADDR_PRIO_BASE) && (prio_off[1:0] == 2'b00) &&
                    (int'(prio_off[7:2]) < NUM_SRC);

  // Out-of-range or mismatched ids never match a gateway, so they are ignored.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_gw
    irq_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .src      (src_irq[i]),
      .edge_sel (edge_sel[i]),
      .claim    (claim_fire && (claim_id == ID_W'(i + 1))),
      .complete (cmpl_hit && (bus_wdata == 32'(i + 1))),
      .pending  (pending_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= '0;
      edge_sel  <= '0;
      threshold <= '0;
      prio      <= '0;
    end else if (bus_we) begin
      case (bus_addr)
        ADDR_ENABLE:    enable    <= bus_wdata[NUM_SRC-1:0];
        ADDR_EDGE_SEL:  edge_sel  <= bus_wdata[NUM_SRC-1:0];
        ADDR_THRESHOLD: threshold <= bus_wdata[PRIO_W-1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_SRC; i++)
        if (prio_hit && (prio_off[7:2] == 6'(i)))
          prio[i] <= bus_wdata[PRIO_W-1:0];
    end
  end

  // Strict greater-than keeps the lowest index on priority ties; priority 0
  // can never beat the initial zero, so it is never selected.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (pending_vec[i] && enable[i] && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        best_id   = ID_W'(i + 1);
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      claim_id <= '0;
      win_prio <= '0;
      ext_irq  <= 1'b0;
    end else begin
      claim_id <= best_id;
      win_prio <= best_prio;
      ext_irq  <= (claim_id != '0) && (win_prio > threshold);
    end
  end

  always_comb begin
    rdata_d = '0;
    case (bus_addr)
      ADDR_PENDING:   rdata_d[NUM_SRC-1:0] = pending_vec;
      ADDR_ENABLE:    rdata_d[NUM_SRC-1:0] = enable;
      ADDR_EDGE_SEL:  rdata_d[NUM_SRC-1:0] = edge_sel;
      ADDR_THRESHOLD: rdata_d[PRIO_W-1:0]  = threshold;
      ADDR_CLAIM:     rdata_d[ID_W-1:0]    = claim_id;
      default: ;
    endcase
    for (int i = 0; i < NUM_SRC; i++)
      if (prio_hit && (prio_off[7:2] == 6'(i)))
        rdata_d[PRIO_W-1:0] = prio[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= bus_we || bus_re;
      bus_rdata <= rd_en ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_periph_irq_arbiter.sv
// Self-checking bench for periph_irq_arbiter: directed scenarios plus
// randomized traffic checked against a priority-pick reference model.
module tb_periph_irq_arbiter;

  localparam int NUM_SRC = 16;
  localparam logic [7:0] A_PEND = 8'h00, A_EN = 8'h04, A_EDGE = 8'h08,
                         A_THR = 8'h0C, A_CLAIM = 8'h10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_SRC-1:0] src_irq = '0;
  logic [7:0]         bus_addr = '0;
  logic [31:0]        bus_wdata = '0;
  logic               bus_we = 1'b0, bus_re = 1'b0;
  logic [31:0]        bus_rdata;
  logic               bus_ready, ext_irq;
  logic [4:0]         claim_id;

  int n_chk = 0, n_fail = 0;
  bit mon_on = 1'b0;

  // Register model of ENABLE/PRIORITY plus the values the selector saw
  // during the previous cycle.
  logic [NUM_SRC-1:0] en_m = '0, snap_en = '0;
  int prio_m[NUM_SRC], snap_prio[NUM_SRC];

  always #5 clk = ~clk;

  periph_irq_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst), .src_irq(src_irq), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .ext_irq(ext_irq),
    .claim_id(claim_id)
  );

  initial foreach (prio_m[i]) begin prio_m[i] = 0; snap_prio[i] = 0; end

  always @(posedge clk) begin
    snap_en   = en_m;
    snap_prio = prio_m;
    if (rst) begin
      en_m = '0;
      foreach (prio_m[i]) prio_m[i] = 0;
    end else if (bus_we) begin
      if (bus_addr == A_EN) en_m = bus_wdata[NUM_SRC-1:0];
      else if (bus_addr >= 8'h40 && bus_addr[1:0] == 2'b00) begin
        int j;
        j = (int'(bus_addr) - 64) / 4;
        if (j < NUM_SRC) prio_m[j] = int'(bus_wdata[2:0]);
      end
    end
  end

  always @(negedge clk) if (mon_on) begin
    n_chk++;
    if ($isunknown({ext_irq, claim_id, bus_ready, bus_rdata})) begin
      n_fail++;
      $display("FAIL no_x ext_irq=%b claim_id=%b ready=%b rdata=%h", ext_irq, claim_id, bus_ready, bus_rdata);
    end
    if (claim_id != 5'd0) begin
      int k;
      k = int'(claim_id) - 1;
      n_chk++;
      if (k >= NUM_SRC || !snap_en[k] || snap_prio[k] == 0) begin
        n_fail++;
        $display("FAIL claim_valid claim_id=%0d required enabled nonzero-priority source", claim_id);
      end
    end
  end

  function automatic logic [7:0] pa(input int i);
    return 8'(64 + 4 * i);
  endfunction

  // Reference pick: find the top priority first, then the lowest index at it.
  function automatic int pick(input int pr[NUM_SRC], input bit act[NUM_SRC]);
    int mx = 0;
    foreach (pr[i]) if (act[i] && pr[i] > mx) mx = pr[i];
    if (mx == 0) return 0;
    foreach (pr[i]) if (act[i] && pr[i] == mx) return i + 1;
    return 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0; src_irq = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic rdy);
    @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d = bus_rdata; rdy = bus_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    n_chk++; if (ext_irq !== 1'b0) begin n_fail++; $display("FAIL rst_ext_irq got=%b exp=0", ext_irq); end
    n_chk++; if (claim_id !== 5'd0) begin n_fail++; $display("FAIL rst_claim_id got=%0d exp=0", claim_id); end
    n_chk++; if (bus_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", bus_ready); end
    n_chk++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", bus_rdata); end
    rst = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic test_registers;
    logic [31:0] d; logic r;
    do_reset;
    wr(A_EN, 32'hABCD_1234);
    rd(A_EN, d, r);
    n_chk++; if (d !== 32'h0000_1234 || r !== 1'b1) begin n_fail++; $display("FAIL reg_enable got=%h rdy=%b exp=00001234 rdy=1", d, r); end
    wr(A_THR, 32'hFFFF_FFF5);
    rd(A_THR, d, r);
    n_chk++; if (d !== 32'd5) begin n_fail++; $display("FAIL reg_threshold got=%h exp=5", d); end
    wr(pa(3), 32'hE);
    rd(pa(3), d, r);
    n_chk++; if (d !== 32'd6) begin n_fail++; $display("FAIL reg_prio3 got=%h exp=6", d); end
    wr(pa(15), 32'h3);
    rd(pa(15), d, r);
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL reg_prio15 got=%h exp=3", d); end
    rd(8'h14, d, r);
    n_chk++; if (d !== 32'h0 || r !== 1'b1) begin n_fail++; $display("FAIL unmapped_rd got=%h rdy=%b exp=0 rdy=1", d, r); end
    rd(8'h80, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_prio_rd got=%h exp=0", d); end
    // Write and read strobed together: the write must land.
    @(negedge clk);
    bus_addr = A_EDGE; bus_wdata = 32'h55; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    n_chk++; if (bus_ready !== 1'b1) begin n_fail++; $display("FAIL we_re_ready got=%b exp=1", bus_ready); end
    rd(A_EDGE, d, r);
    n_chk++; if (d !== 32'h55) begin n_fail++; $display("FAIL we_re_write got=%h exp=55", d); end
    // Reset during an access discards it.
    @(negedge clk);
    bus_addr = A_EN; bus_wdata = 32'hFFFF; bus_we = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; rst = 1'b0;
    n_chk++; if (bus_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=0", bus_ready); end
    rd(A_EN, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_enable got=%h exp=0", d); end
  endtask

  task automatic test_latency;
    logic [31:0] d; logic r;
    do_reset;
    wr(pa(2), 3); wr(A_EN, 32'h4); wr(A_THR, 0);
    @(negedge clk); src_irq[2] = 1'b1;
    tick(2);
    n_chk++; if (ext_irq !== 1'b0) begin n_fail++; $display("FAIL lat_early got=%b exp=0", ext_irq); end
    tick(1);
    n_chk++; if (ext_irq !== 1'b1) begin n_fail++; $display("FAIL lat_3edges got=%b exp=1", ext_irq); end
    rd(A_CLAIM, d, r);
    n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL claim_src2 got=%0d exp=3", d); end
    tick(1);
    n_chk++; if (ext_irq !== 1'b1) begin n_fail++; $display("FAIL claim_drop_1 got=%b exp=1", ext_irq); end
    tick(1);
    n_chk++; if (ext_irq !== 1'b0) begin n_fail++; $display("FAIL claim_drop_2 got=%b exp=0", ext_irq); end
    src_irq[2] = 1'b0;
    wr(A_CLAIM, 3);
  endtask

  task automatic test_priority_order;
    logic [31:0] d; logic r;
    int exp_ids[4] = '{13, 6, 10, 0};
    do_reset;
    wr(pa(5), 2); wr(pa(9), 2); wr(pa(12), 4);
    wr(A_EN, 32'h1220);
    @(negedge clk); src_irq = 16'h1220;
    tick(3);
    foreach (exp_ids[i]) begin
      rd(A_CLAIM, d, r);
      n_chk++;
      if (d !== 32'(exp_ids[i])) begin n_fail++; $display("FAIL prio_order_%0d got=%0d exp=%0d", i, d, exp_ids[i]); end
    end
  endtask

  task automatic test_threshold;
    logic [31:0] d; logic r;
    do_reset;
    wr(A_THR, 4); wr(pa(0), 4); wr(A_EN, 1);
    @(negedge clk); src_irq[0] = 1'b1;
    tick(5);
    n_chk++; if (ext_irq !== 1'b0) begin n_fail++; $display("FAIL thr_masked got=%b exp=0", ext_irq); end
    rd(A_PEND, d, r);
    n_chk++; if (d[0] !== 1'b1) begin n_fail++; $display("FAIL thr_pending got=%h exp bit0=1", d); end
    wr(A_THR, 3);
    tick(1);
    n_chk++; if (ext_irq !== 1'b1) begin n_fail++; $display("FAIL thr_lowered got=%b exp=1", ext_irq); end
  endtask

  task automatic pulse7;
    @(negedge clk); src_irq[7] = 1'b1;
    @(negedge clk); src_irq[7] = 1'b0;
  endtask

  task automatic test_edge_mode;
    logic [31:0] d; logic r;
    do_reset;
    wr(A_EDGE, 32'h80); wr(pa(7), 1); wr(A_EN, 32'h80);
    repeat (3) pulse7();
    tick(3);
    rd(A_CLAIM, d, r);
    n_chk++; if (d !== 32'd8) begin n_fail++; $display("FAIL edge_claim1 got=%0d exp=8", d); end
    rd(A_CLAIM, d, r);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL edge_claim2 got=%0d exp=0", d); end
    pulse7();
    wr(A_CLAIM, 8);
    rd(A_PEND, d, r);
    n_chk++; if (d[7] !== 1'b0) begin n_fail++; $display("FAIL edge_dropped got=%h exp bit7=0", d); end
    pulse7();
    tick(1);
    rd(A_PEND, d, r);
    n_chk++; if (d[7] !== 1'b1) begin n_fail++; $display("FAIL edge_repend got=%h exp bit7=1", d); end
  endtask

  task automatic test_complete;
    logic [31:0] d; logic r;
    do_reset;
    wr(pa(4), 2); wr(A_EN, 32'h10);
    @(negedge clk); src_irq[4] = 1'b1;
    tick(3);
    rd(A_CLAIM, d, r);
    n_chk++; if (d !== 32'd5) begin n_fail++; $display("FAIL cmpl_claim got=%0d exp=5", d); end
    wr(A_CLAIM, 0); wr(A_CLAIM, 17);
    rd(A_PEND, d, r);
    n_chk++; if (d[4] !== 1'b0) begin n_fail++; $display("FAIL cmpl_bad_ids got=%h exp bit4=0", d); end
    wr(A_CLAIM, 5);
    rd(A_PEND, d, r);
    n_chk++; if (d[4] !== 1'b1) begin n_fail++; $display("FAIL cmpl_level_repend got=%h exp bit4=1", d); end
    wr(A_CLAIM, 5);
    rd(A_PEND, d, r);
    n_chk++; if (d[4] !== 1'b1) begin n_fail++; $display("FAIL cmpl_not_in_service got=%h exp bit4=1", d); end
    rd(A_CLAIM, d, r);
    n_chk++; if (d !== 32'd5) begin n_fail++; $display("FAIL cmpl_reclaim got=%0d exp=5", d); end
    src_irq[4] = 1'b0;
    wr(A_CLAIM, 5); wr(A_CLAIM, 5);
    rd(A_PEND, d, r);
    n_chk++; if (d[4] !== 1'b0) begin n_fail++; $display("FAIL cmpl_idle got=%h exp bit4=0", d); end
  endtask

  task automatic test_random_claims;
    logic [31:0] d; logic r;
    logic [15:0] en, raise;
    int pr[NUM_SRC]; bit act[NUM_SRC];
    int exp;
    for (int rep = 0; rep < 4; rep++) begin
      do_reset;
      en = 16'($urandom); raise = 16'($urandom);
      for (int i = 0; i < NUM_SRC; i++) begin
        pr[i] = $urandom_range(0, 7);
        wr(pa(i), 32'(pr[i]));
      end
      wr(A_EN, {16'h0, en});
      @(negedge clk); src_irq = raise;
      tick(4);
      for (int i = 0; i < NUM_SRC; i++) act[i] = raise[i] && en[i] && (pr[i] != 0);
      for (int k = 0; k <= NUM_SRC; k++) begin
        exp = pick(pr, act);
        rd(A_CLAIM, d, r);
        n_chk++;
        if (d !== 32'(exp)) begin n_fail++; $display("FAIL rand_claim rep=%0d step=%0d got=%0d exp=%0d", rep, k, d, exp); end
        if (exp == 0) break;
        act[exp-1] = 1'b0;
      end
    end
  endtask

  task automatic test_random_traffic;
    do_reset;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      bus_we = 1'b0; bus_re = 1'b0;
      if ($urandom_range(0, 3) == 0) src_irq = 16'($urandom);
      case ($urandom_range(0, 6))
        0: begin bus_we = 1'b1; bus_addr = A_EN;   bus_wdata = $urandom; end
        1: begin bus_we = 1'b1; bus_addr = pa($urandom_range(0, NUM_SRC-1)); bus_wdata = $urandom; end
        2: begin bus_we = 1'b1; bus_addr = A_THR;  bus_wdata = $urandom; end
        3: begin bus_we = 1'b1; bus_addr = A_EDGE; bus_wdata = $urandom; end
        4: begin bus_re = 1'b1; bus_addr = A_CLAIM; end
        5: begin bus_we = 1'b1; bus_addr = A_CLAIM; bus_wdata = $urandom_range(0, 18); end
        default: begin bus_re = 1'b1; bus_addr = 8'($urandom); end
      endcase
    end
    do_reset;
  endtask

  initial begin
    test_reset;
    test_registers;
    test_latency;
    test_priority_order;
    test_threshold;
    test_edge_mode;
    test_complete;
    test_random_claims;
    test_random_traffic;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
